// File: rtl/roce_stack_axi_mem_responder_if.sv
// AXI4 bus bundle between the RoCE stack data-bus master and the memory responder.
// Single-bit IDs, 64-bit addresses, data width set by AXI4_DATA_WIDTH.
interface roce_stack_axi_mem_responder_if #(
    parameter int unsigned AXI4_DATA_WIDTH = 512
) ();
    localparam int unsigned BYTES = AXI4_DATA_WIDTH / 8;

    logic                       awid;
    logic [63:0]                awaddr;
    logic [7:0]                 awlen;
    logic [2:0]                 awsize;
    logic [1:0]                 awburst;
    logic                       awvalid;
    logic                       awready;
    logic [AXI4_DATA_WIDTH-1:0] wdata;
    logic [BYTES-1:0]           wstrb;
    logic                       wlast;
    logic                       wvalid;
    logic                       wready;
    logic                       bid;
    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       bready;
    logic                       arid;
    logic [63:0]                araddr;
    logic [7:0]                 arlen;
    logic [2:0]                 arsize;
    logic [1:0]                 arburst;
    logic                       arvalid;
    logic                       arready;
    logic                       rid;
    logic [AXI4_DATA_WIDTH-1:0] rdata;
    logic [1:0]                 rresp;
    logic                       rlast;
    logic                       rvalid;
    logic                       rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/roce_stack_axi_mem_responder.sv
// AXI4 slave backed by on-chip word memory: one burst in flight, byte-enabled writes,
// full-width reads through a 2-entry output buffer, OKAY/SLVERR/DECERR responses.
module roce_stack_axi_mem_responder #(
    parameter int unsigned AXI4_DATA_WIDTH = 512,
    parameter int unsigned MEM_DEPTH       = 1024,
    parameter logic [63:0] BASE_ADDR       = 64'h0
) (
    input  logic                           axis_aclk_i,
    input  logic                           aresetn_i,
    roce_stack_axi_mem_responder_if.slave  s_axi
);
    localparam int unsigned BYTES  = AXI4_DATA_WIDTH / 8;
    localparam int unsigned BSHIFT = $clog2(BYTES);
    localparam int unsigned IW     = $clog2(MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

    state_t                     state_q, state_d;
    logic                       last_rd_q, last_rd_d;
    logic                       id_q, id_d;
    logic [1:0]                 resp_q, resp_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [7:0]                 len_q, len_d;
    logic                       fixed_q, fixed_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [8:0]                 iss_q, iss_d;
    logic [AXI4_DATA_WIDTH-1:0] rbuf_q [2];
    logic                       rbuf_wp_q, rbuf_wp_d;
    logic                       rbuf_rp_q, rbuf_rp_d;
    logic [1:0]                 rbuf_cnt_q, rbuf_cnt_d;
    logic [AXI4_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic        grant_wr, grant_rd, aw_hs, ar_hs;
    logic        rvalid, r_pop, r_issue, wr_en, last_beat;
    logic [63:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [1:0]  req_burst;

    function automatic logic [1:0] burst_resp(input logic [63:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [64:0] word;
        word = {1'b0, (addr - BASE_ADDR) >> BSHIFT};
        if (addr < BASE_ADDR)
            return RESP_DECERR;
        else if (burst == BURST_INCR && (word + {57'b0, len}) >= 65'(MEM_DEPTH))
            return RESP_DECERR;
        else if (burst == BURST_FIXED && word >= 65'(MEM_DEPTH))
            return RESP_DECERR;
        else if (size != 3'(BSHIFT) || burst[1])
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [IW-1:0] start_idx(input logic [63:0] addr);
        logic [63:0] word;
        word = (addr - BASE_ADDR) >> BSHIFT;
        return word[IW-1:0];
    endfunction

    // Both valid: the channel not granted last time wins; last_rd_q resets to 1 so write goes first.
    always_comb begin
        grant_wr  = s_axi.awvalid & (~s_axi.arvalid | last_rd_q);
        grant_rd  = s_axi.arvalid & ~grant_wr;
        aw_hs     = (state_q == IDLE) & grant_wr;
        ar_hs     = (state_q == IDLE) & grant_rd;
        req_addr  = grant_wr ? s_axi.awaddr  : s_axi.araddr;
        req_len   = grant_wr ? s_axi.awlen   : s_axi.arlen;
        req_size  = grant_wr ? s_axi.awsize  : s_axi.arsize;
        req_burst = grant_wr ? s_axi.awburst : s_axi.arburst;
        last_beat = (cnt_q == len_q);
        rvalid    = (rbuf_cnt_q != 2'd0);
        r_pop     = rvalid & s_axi.rready;
        r_issue   = (state_q == RD_DATA) & (iss_q <= {1'b0, len_q}) & ((rbuf_cnt_q != 2'd2) | r_pop);
        wr_en     = aresetn_i & (state_q == WR_DATA) & s_axi.wvalid & (resp_q == RESP_OKAY);
    end

    assign s_axi.awready = aw_hs;
    assign s_axi.arready = ar_hs;
    assign s_axi.wready  = (state_q == WR_DATA);
    assign s_axi.bvalid  = (state_q == WR_RESP);
    assign s_axi.bid     = id_q;
    assign s_axi.bresp   = resp_q;
    assign s_axi.rvalid  = rvalid;
    assign s_axi.rid     = id_q;
    assign s_axi.rresp   = resp_q;
    assign s_axi.rlast   = rvalid & last_beat;
    assign s_axi.rdata   = rbuf_q[rbuf_rp_q];

    always_comb begin
        state_d    = state_q;
        last_rd_d  = last_rd_q;
        id_d       = id_q;
        resp_d     = resp_q;
        idx_d      = idx_q;
        len_d      = len_q;
        fixed_d    = fixed_q;
        cnt_d      = cnt_q;
        iss_d      = iss_q;
        rbuf_wp_d  = rbuf_wp_q ^ r_issue;
        rbuf_rp_d  = rbuf_rp_q ^ r_pop;
        rbuf_cnt_d = rbuf_cnt_q + 2'(r_issue) - 2'(r_pop);
        case (state_q)
            IDLE: begin
                if (aw_hs | ar_hs) begin
                    state_d   = aw_hs ? WR_DATA : RD_DATA;
                    last_rd_d = ar_hs;
                    id_d      = aw_hs ? s_axi.awid : s_axi.arid;
                    resp_d    = burst_resp(req_addr, req_len, req_size, req_burst);
                    idx_d     = start_idx(req_addr);
                    len_d     = req_len;
                    fixed_d   = (req_burst == BURST_FIXED);
                    cnt_d     = '0;
                    iss_d     = '0;
                end
            end
            WR_DATA: begin
                if (s_axi.wvalid) begin
                    if (!fixed_q) idx_d = idx_q + IW'(1);
                    if ((s_axi.wlast != last_beat) && (resp_q == RESP_OKAY)) resp_d = RESP_SLVERR;
                    if (last_beat) state_d = WR_RESP;
                    else           cnt_d   = cnt_q + 8'd1;
                end
            end
            WR_RESP: begin
                if (s_axi.bready) state_d = IDLE;
            end
            RD_DATA: begin
                // Issue side (iss_q/idx_q) runs ahead of the output beat counter (cnt_q) by the buffer depth.
                if (r_issue) begin
                    iss_d = iss_q + 9'd1;
                    if (!fixed_q) idx_d = idx_q + IW'(1);
                end
                if (r_pop) begin
                    if (last_beat) state_d = IDLE;
                    else           cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk_i) begin
        if (!aresetn_i) begin
            state_q    <= IDLE;
            last_rd_q  <= 1'b1;
            id_q       <= 1'b0;
            resp_q     <= RESP_OKAY;
            idx_q      <= '0;
            len_q      <= '0;
            fixed_q    <= 1'b0;
            cnt_q      <= '0;
            iss_q      <= '0;
            rbuf_wp_q  <= 1'b0;
            rbuf_rp_q  <= 1'b0;
            rbuf_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_rd_q  <= last_rd_d;
            id_q       <= id_d;
            resp_q     <= resp_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            fixed_q    <= fixed_d;
            cnt_q      <= cnt_d;
            iss_q      <= iss_d;
            rbuf_wp_q  <= rbuf_wp_d;
            rbuf_rp_q  <= rbuf_rp_d;
            rbuf_cnt_q <= rbuf_cnt_d;
        end
    end

    always_ff @(posedge axis_aclk_i) begin
        if (!aresetn_i) begin
            for (int unsigned i = 0; i < 2; i++) rbuf_q[i] <= '0;
        end else if (r_issue) begin
            rbuf_q[rbuf_wp_q] <= (resp_q == RESP_OKAY) ? mem[idx_q] : '0;
        end
    end

    always_ff @(posedge axis_aclk_i) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (s_axi.wstrb[b]) mem[idx_q][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_roce_stack_axi_mem_responder.sv
// Scoreboard bench for the AXI memory responder: tasks push expected B/R responses from a
// word-array reference model, a negedge monitor pops and compares on every handshake.
module tb_roce_stack_axi_mem_responder;
    localparam int unsigned DW    = 512;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
    localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    typedef struct packed {logic id; logic [1:0] resp;} bexp_t;
    typedef struct packed {logic id; logic [1:0] resp; logic last; logic [DW-1:0] data;} rexp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   b_seen = 0;
    int   r_last_seen = 0;
    bit   rr_rand = 0;
    bit   br_rand = 0;
    time  aw_t, ar_t;
    bexp_t bq[$];
    rexp_t rq[$];
    logic [DW-1:0] mem_m [longint unsigned];
    logic [DW-1:0] wd [256];
    logic [NB-1:0] ws [256];

    roce_stack_axi_mem_responder_if #(.AXI4_DATA_WIDTH(DW)) bus ();

    roce_stack_axi_mem_responder #(
        .AXI4_DATA_WIDTH(DW),
        .MEM_DEPTH(DEPTH),
        .BASE_ADDR(BASE)
    ) dut (
        .axis_aclk_i(clk),
        .aresetn_i(rstn),
        .s_axi(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [519:0] act, input logic [519:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_awready"}, bus.awready, 0);
        chk({p, "_arready"}, bus.arready, 0);
        chk({p, "_wready"},  bus.wready,  0);
        chk({p, "_bvalid"},  bus.bvalid,  0);
        chk({p, "_rvalid"},  bus.rvalid,  0);
        chk({p, "_rlast"},   bus.rlast,   0);
        chk({p, "_ids"},     {bus.bid, bus.rid}, 0);
        chk({p, "_resps"},   {bus.bresp, bus.rresp}, 0);
        chk({p, "_rdata"},   bus.rdata,   0);
    endtask

    // Reference response rules worked out on whole word numbers.
    function automatic logic [1:0] ref_resp(input logic [63:0] addr, input int len,
                                            input logic [2:0] size, input logic [1:0] burst);
        longint unsigned word;
        if (addr < BASE) return DECERR;
        word = (addr - BASE) / NB;
        if (burst == INCR && word + longint'(len) > DEPTH - 1) return DECERR;
        if (burst == FIXED && word > DEPTH - 1) return DECERR;
        if (size != 3'd6 || burst == WRAP || burst == 2'b11) return SLVERR;
        return OKAY;
    endfunction

    function automatic logic [63:0] waddr(input longint unsigned w);
        return BASE + 64'(w) * NB;
    endfunction

    task automatic fill(input int n, input logic [7:0] seed);
        for (int i = 0; i < n; i++) begin
            wd[i] = {NB{8'(seed + 8'(i))}};
            ws[i] = '1;
        end
    endtask

    task automatic do_write(input logic id, input logic [63:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int last_at);
        logic [1:0] resp;
        longint unsigned w, ix;
        logic [DW-1:0] nw;
        int to, b0;
        resp = ref_resp(addr, len, size, burst);
        w = (addr >= BASE) ? (addr - BASE) / NB : 0;
        for (int b = 0; b <= len; b++) begin
            if (resp == OKAY) begin
                ix = (burst == INCR) ? w + longint'(b) : w;
                nw = mem_m.exists(ix) ? mem_m[ix] : '0;
                for (int k = 0; k < NB; k++) if (ws[b][k]) nw[k*8 +: 8] = wd[b][k*8 +: 8];
                mem_m[ix] = nw;
            end
            if ((b == last_at) != (b == len) && resp == OKAY) resp = SLVERR;
        end
        bq.push_back('{id: id, resp: resp});
        b0 = b_seen;
        @(posedge clk); #1;
        bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
        bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
        @(negedge clk);
        chk("wready_before_aw", bus.wready, 0);
        to = 0;
        while (!bus.awready && to < 300) begin @(negedge clk); to++; end
        if (!bus.awready) begin timeout("aw_handshake"); bus.awvalid = 1'b0; return; end
        @(posedge clk); aw_t = $time; #1;
        bus.awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if ($urandom_range(0, 3) == 0) begin bus.wvalid = 1'b0; @(posedge clk); #1; end
            bus.wvalid = 1'b1; bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = (b == last_at);
            @(negedge clk);
            if (b == 0) chk("wready_after_aw", bus.wready, 1);
            to = 0;
            while (!bus.wready && to < 50) begin @(negedge clk); to++; end
            if (!bus.wready) begin timeout("w_handshake"); bus.wvalid = 1'b0; return; end
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        @(negedge clk);
        chk("bvalid_after_last_w", bus.bvalid, 1);
        to = 0;
        while (b_seen == b0 && to < 300) begin @(negedge clk); to++; end
        if (b_seen == b0) timeout("b_handshake");
    endtask

    task automatic do_read(input logic id, input logic [63:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input bit lat_chk);
        logic [1:0] resp;
        longint unsigned w, ix;
        logic [DW-1:0] d;
        int to, r0;
        resp = ref_resp(addr, len, size, burst);
        w = (addr >= BASE) ? (addr - BASE) / NB : 0;
        for (int b = 0; b <= len; b++) begin
            ix = (burst == INCR) ? w + longint'(b) : w;
            d  = (resp == OKAY && mem_m.exists(ix)) ? mem_m[ix] : '0;
            rq.push_back('{id: id, resp: resp, last: (b == len), data: d});
        end
        r0 = r_last_seen;
        @(posedge clk); #1;
        bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
        bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
        to = 0;
        @(negedge clk);
        while (!bus.arready && to < 300) begin @(negedge clk); to++; end
        if (!bus.arready) begin timeout("ar_handshake"); bus.arvalid = 1'b0; return; end
        @(posedge clk); ar_t = $time; #1;
        bus.arvalid = 1'b0;
        if (lat_chk) begin
            @(negedge clk); chk("rvalid_cycle1", bus.rvalid, 0);
            @(negedge clk); chk("rvalid_cycle2", bus.rvalid, 1);
        end
        to = 0;
        while (r_last_seen == r0 && to < 3000) begin @(negedge clk); to++; end
        if (r_last_seen == r0) timeout("r_last");
    endtask

    // Ready generators: either held high or a fresh coin flip each cycle.
    initial begin
        bus.rready = 1'b1;
        bus.bready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.rready = rr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.bready = br_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    logic  p_rv = 1'b0;
    logic  p_rr = 1'b0;
    rexp_t p_r;
    always @(negedge clk) begin
        rexp_t cur, re;
        bexp_t be;
        if (!rstn) begin
            p_rv = 1'b0;
        end else begin
            cur = '{id: bus.rid, resp: bus.rresp, last: bus.rlast, data: bus.rdata};
            if (p_rv && !p_rr) begin
                chk("r_stall_valid", bus.rvalid, 1);
                chk("r_stall_hold", cur, p_r);
            end
            if (bus.bvalid && bus.bready) begin
                if (bq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_b: got bresp %0d, expected no response", bus.bresp);
                end else begin
                    be = bq.pop_front();
                    chk("bid", bus.bid, be.id);
                    chk("bresp", bus.bresp, be.resp);
                end
                b_seen++;
            end
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_r: got rresp %0d, expected no beat", bus.rresp);
                end else begin
                    re = rq.pop_front();
                    chk("rid", bus.rid, re.id);
                    chk("rresp", bus.rresp, re.resp);
                    chk("rlast", bus.rlast, re.last);
                    chk("rdata", bus.rdata, re.data);
                end
                if (bus.rlast) r_last_seen++;
            end
            p_rv = bus.rvalid;
            p_rr = bus.rready;
            p_r  = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned w;
        int len;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        bus.awid = 1'b0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.arid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk); #1 rstn = 1'b1;

        // Simultaneous AW/AR after reset: write first, then the out-of-range read.
        fill(4, 8'hA0);
        fork
            do_write(1'b1, BASE + 64'h40, 3, 3'd6, INCR, 3);
            do_read(1'b0, waddr(1020), 7, 3'd6, INCR, 1'b1);
            begin
                @(posedge clk); @(negedge clk);
                chk("arb_awready", bus.awready, 1);
                chk("arb_arready", bus.arready, 0);
            end
        join
        chk("arb_write_first", aw_t < ar_t, 1);
        do_read(1'b1, BASE + 64'h40, 3, 3'd6, INCR, 1'b1);

        // Partial strobes, with low address bits that must be ignored.
        fill(1, 8'h11);
        do_write(1'b0, waddr(5), 0, 3'd6, INCR, 0);
        fill(1, 8'h22); ws[0] = 64'h0F;
        do_write(1'b0, waddr(5) + 64'd7, 0, 3'd6, INCR, 0);
        do_read(1'b0, waddr(5) + 64'd3, 0, 3'd6, INCR, 1'b0);

        // End-of-memory boundary: last legal burst, then one beat past, then DECERR write.
        fill(4, 8'h60);
        do_write(1'b1, waddr(1020), 3, 3'd6, INCR, 3);
        do_read(1'b1, waddr(1020), 4, 3'd6, INCR, 1'b0);
        fill(8, 8'hE0);
        do_write(1'b0, waddr(1020), 7, 3'd6, INCR, 7);
        do_read(1'b0, waddr(1020), 3, 3'd6, INCR, 1'b0);
        do_read(1'b0, BASE - 64'd64, 0, 3'd6, INCR, 1'b0);
        do_write(1'b1, BASE - 64'd64, 0, 3'd6, INCR, 0);
        do_read(1'b1, waddr(1024), 0, 3'd6, FIXED, 1'b0);

        // FIXED bursts stay on one word.
        fill(4, 8'h30);
        do_write(1'b1, waddr(30), 3, 3'd6, FIXED, 3);
        do_read(1'b0, waddr(30), 2, 3'd6, FIXED, 1'b0);

        // Protocol errors.
        fill(4, 8'h40);
        do_write(1'b0, waddr(40), 3, 3'd6, WRAP, 3);
        do_write(1'b1, waddr(44), 3, 3'd6, INCR, 2);
        do_write(1'b0, waddr(48), 1, 3'd6, INCR, -1);
        do_read(1'b1, waddr(30), 1, 3'd3, INCR, 1'b0);
        do_read(1'b0, waddr(30), 1, 3'd6, 2'b11, 1'b0);

        // Random bursts with random backpressure on both response channels.
        rr_rand = 1; br_rand = 1;
        for (int it = 0; it < 4; it++) begin
            len = (it == 0) ? 15 : $urandom_range(0, 15);
            w = longint'($urandom_range(100, 900));
            for (int i = 0; i <= len; i++) begin
                for (int k = 0; k < DW / 32; k++) wd[i][k*32 +: 32] = $urandom();
                ws[i] = '1;
            end
            do_write(1'($urandom_range(0, 1)), waddr(w), len, 3'd6, INCR, len);
            for (int i = 0; i <= len; i++) begin
                for (int k = 0; k < DW / 32; k++) wd[i][k*32 +: 32] = $urandom();
                ws[i] = {$urandom(), $urandom()};
            end
            do_write(1'($urandom_range(0, 1)), waddr(w), len, 3'd6, INCR, len);
            do_read(1'($urandom_range(0, 1)), waddr(w), len, 3'd6, INCR, 1'b0);
        end
        rr_rand = 0; br_rand = 0;

        // Reset while beat 2 of an 8-beat write is on the bus.
        fill(8, 8'h50);
        do_write(1'b0, waddr(200), 7, 3'd6, INCR, 7);
        @(posedge clk); #1;
        bus.awid = 1'b1; bus.awaddr = waddr(200); bus.awlen = 8'd7;
        bus.awsize = 3'd6; bus.awburst = INCR; bus.awvalid = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 20 && !bus.awready; t++) @(negedge clk);
        chk("rst_aw_accept", bus.awready, 1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.wvalid = 1'b1; bus.wdata = {16{32'hC0DE_0000 + 32'(b)}}; bus.wstrb = '1; bus.wlast = 1'b0;
            if (b == 2) begin
                rstn = 1'b0;
            end else begin
                mem_m[200 + b] = {16{32'hC0DE_0000 + 32'(b)}};
                @(negedge clk);
                chk("rst_wready", bus.wready, 1);
                @(posedge clk); #1;
            end
        end
        @(posedge clk); @(negedge clk);
        chk_reset("rst_mid");
        @(posedge clk); #1;
        bus.wvalid = 1'b0; rstn = 1'b1;
        repeat (3) begin @(negedge clk); chk("rst_no_bvalid", bus.bvalid, 0); end
        do_read(1'b1, waddr(200), 3, 3'd6, INCR, 1'b1);

        repeat (4) @(posedge clk);
        chk("b_queue_drained", bq.size(), 0);
        chk("r_queue_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
